// File: rtl/sensor_sched_pkg.sv
// sensor_sched_pkg: shared state encoding, frame size and checksum helpers for the DHT11 read scheduler
package sensor_sched_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_ARB, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_CHECK, S_FAIL, S_RESPOND, S_COOLDOWN
   } state_t;
   localparam int DHT_FRAME_BYTES = 5;
   function automatic logic [7:0] checksum(input logic [7:0] hi, input logic [7:0] hf, input logic [7:0] ti, input logic [7:0] tf);
      return hi + hf + ti + tf;
   endfunction
   function automatic logic frame_ok(input logic [8*DHT_FRAME_BYTES-1:0] f);
      return (checksum(f[39:32], f[31:24], f[23:16], f[15:8]) == f[7:0]) && (|f);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts just after the last granted index
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   logic [IW-1:0] last, sel_hi, sel_lo;
   logic hit_hi, hit_lo;
   // lowest requester above the last grant wins, otherwise wrap to the lowest requester overall
   always_comb begin
      sel_hi = '0;
      sel_lo = '0;
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && i > int'(last)) begin
            sel_hi = IW'(i);
            hit_hi = 1'b1;
         end
         if (req[i]) begin
            sel_lo = IW'(i);
            hit_lo = 1'b1;
         end
      end
      gnt = hit_hi ? (N'(1) << sel_hi) : hit_lo ? (N'(1) << sel_lo) : '0;
   end
   // remember who was served so the next search starts after it
   always_ff @(posedge clock or posedge reset)
      if (reset) last <= IW'(N - 1);
      else if (advance && hit_lo) last <= hit_hi ? sel_hi : sel_lo;
endmodule

// File: rtl/sensor_read_scheduler.sv
// sensor_read_scheduler: shares one DHT11 decoder between requesters and a periodic auto-read (SENSOR_RETRY_EN enables retries)
module sensor_read_scheduler
   import sensor_sched_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int MIN_GAP_CYCLES = 50_000_000,
   parameter int AUTO_PERIOD    = 100_000_000,
   parameter int START_TIMEOUT  = 16,
   parameter int DONE_TIMEOUT   = 5_000_000,
   parameter int MAX_RETRY      = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [N_REQ-1:0] done,
   input  logic             auto_en,
   output logic             busy,
   output logic [7:0]       rd_hum_int,
   output logic [7:0]       rd_hum_float,
   output logic [7:0]       rd_temp_int,
   output logic [7:0]       rd_temp_float,
   output logic             rd_valid,
   output logic             rd_error,
   output logic             dec_enable,
   output logic             dec_reset,
   input  logic             dec_hold,
   input  logic [7:0]       dec_hum_int,
   input  logic [7:0]       dec_hum_float,
   input  logic [7:0]       dec_temp_int,
   input  logic [7:0]       dec_temp_float,
   input  logic [7:0]       dec_checksum
);
`ifdef SENSOR_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif
   localparam logic [31:0] ST_LAST  = 32'(START_TIMEOUT - 1);
   localparam logic [31:0] DT_LAST  = 32'(DONE_TIMEOUT - 1);
   localparam logic [31:0] GAP_LAST = 32'(MIN_GAP_CYCLES - 1);
   localparam logic [31:0] AP_LAST  = 32'(AUTO_PERIOD - 1);
   state_t state;
   logic [31:0] cnt, per_cnt;
   logic [3:0] retries;
   logic again, auto_pend, auto_take, advance;
   logic [N_REQ-1:0] arb_gnt;
   assign advance   = (state == S_ARB) && (|req);
   assign auto_take = (state == S_ARB) && (req == '0);
   rr_arbiter #(.N(N_REQ)) u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    (req),
      .advance(advance),
      .gnt    (arb_gnt)
   );
   // periodic auto-read tick; extra ticks collapse into one pending read
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         per_cnt   <= '0;
         auto_pend <= 1'b0;
      end else if (!auto_en) begin
         per_cnt   <= '0;
         auto_pend <= 1'b0;
      end else begin
         per_cnt <= (per_cnt == AP_LAST) ? '0 : per_cnt + 32'd1;
         if (per_cnt == AP_LAST) auto_pend <= 1'b1;
         else if (auto_take) auto_pend <= 1'b0;
      end
   // transaction sequencer: arbitrate, pulse the decoder, supervise hold, validate and respond
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         retries       <= '0;
         again         <= 1'b0;
         gnt           <= '0;
         done          <= '0;
         busy          <= 1'b0;
         dec_enable    <= 1'b0;
         dec_reset     <= 1'b0;
         rd_hum_int    <= '0;
         rd_hum_float  <= '0;
         rd_temp_int   <= '0;
         rd_temp_float <= '0;
         rd_valid      <= 1'b0;
         rd_error      <= 1'b0;
      end else begin
         dec_enable <= 1'b1;
         dec_reset  <= 1'b0;
         done       <= '0;
         case (state)
            S_IDLE: if (|req || auto_pend) state <= S_ARB;
            S_ARB: begin
               gnt     <= arb_gnt;
               retries <= '0;
               if (|req || auto_pend) begin
                  state     <= S_START;
                  dec_reset <= 1'b1;
                  busy      <= 1'b1;
               end else state <= S_IDLE;
            end
            S_START: begin
               cnt   <= '0;
               state <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               cnt <= cnt + 32'd1;
               if (dec_hold) begin
                  cnt   <= '0;
                  state <= S_WAIT_DONE;
               end else if (cnt == ST_LAST) state <= S_FAIL;
            end
            S_WAIT_DONE: begin
               cnt <= cnt + 32'd1;
               if (!dec_hold) state <= S_CHECK;
               else if (cnt == DT_LAST) state <= S_FAIL;
            end
            S_CHECK:
               if (frame_ok({dec_hum_int, dec_hum_float, dec_temp_int, dec_temp_float, dec_checksum})) begin
                  rd_hum_int    <= dec_hum_int;
                  rd_hum_float  <= dec_hum_float;
                  rd_temp_int   <= dec_temp_int;
                  rd_temp_float <= dec_temp_float;
                  rd_valid      <= 1'b1;
                  rd_error      <= 1'b0;
                  done          <= gnt & req;
                  state         <= S_RESPOND;
               end else state <= S_FAIL;
            S_FAIL:
               if (RETRY_EN && int'(retries) < MAX_RETRY) begin
                  retries <= retries + 4'd1;
                  again   <= 1'b1;
                  cnt     <= '0;
                  state   <= S_COOLDOWN;
               end else begin
                  rd_valid <= 1'b0;
                  rd_error <= 1'b1;
                  done     <= gnt & req;
                  state    <= S_RESPOND;
               end
            S_RESPOND: begin
               gnt   <= '0;
               cnt   <= '0;
               state <= S_COOLDOWN;
            end
            S_COOLDOWN: begin
               cnt <= cnt + 32'd1;
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  again <= 1'b0;
                  if (again) begin
                     state     <= S_START;
                     dec_reset <= 1'b1;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_sensor_read_scheduler.sv
// tb_sensor_read_scheduler: directed scenarios against a simple DHT11 decoder model
module tb_sensor_read_scheduler;
   localparam int N = 2, GAP = 200, PER = 1000, STO = 16, DTO = 100, MR = 2;
`ifdef SENSOR_RETRY_EN
   localparam int TRIES = MR + 1;
`else
   localparam int TRIES = 1;
`endif
   logic clock = 1'b0, reset = 1'b1, auto_en = 1'b0, dead = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt, done;
   logic busy, rd_valid, rd_error, dec_enable, dec_reset, dec_hold;
   logic [7:0] rd_hi, rd_hf, rd_ti, rd_tf;
   logic [7:0] hi = '0, hf = '0, ti = '0, tf = '0, cs = '0;
   int total = 0, bad = 0, cyc = 0, n_start = 0, mcnt = -1;

   sensor_read_scheduler #(
      .N_REQ(N), .MIN_GAP_CYCLES(GAP), .AUTO_PERIOD(PER),
      .START_TIMEOUT(STO), .DONE_TIMEOUT(DTO), .MAX_RETRY(MR)
   ) dut (
      .clock(clock), .reset(reset), .req(req), .gnt(gnt), .done(done),
      .auto_en(auto_en), .busy(busy),
      .rd_hum_int(rd_hi), .rd_hum_float(rd_hf), .rd_temp_int(rd_ti), .rd_temp_float(rd_tf),
      .rd_valid(rd_valid), .rd_error(rd_error), .dec_enable(dec_enable), .dec_reset(dec_reset),
      .dec_hold(dec_hold), .dec_hum_int(hi), .dec_hum_float(hf), .dec_temp_int(ti),
      .dec_temp_float(tf), .dec_checksum(cs)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // decoder model: hold rises 2 cycles after the start pulse and stays high for 20 cycles
   always @(posedge clock or posedge reset)
      if (reset) begin
         mcnt     <= -1;
         dec_hold <= 1'b0;
      end else if (dec_reset) begin
         mcnt    <= dead ? -1 : 0;
         n_start <= n_start + 1;
      end else if (mcnt >= 0) begin
         mcnt <= mcnt + 1;
         if (mcnt == 2) dec_hold <= 1'b1;
         if (mcnt == 22) begin
            dec_hold <= 1'b0;
            mcnt     <= -1;
         end
      end

   task automatic wait_start(input int limit, output bit ok, output int lat);
      ok = 1'b0; lat = 0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clock);
         if (dec_reset === 1'b1) begin ok = 1'b1; lat = i; break; end
      end
   endtask

   task automatic wait_done(input int limit, output bit ok, output int lat);
      ok = 1'b0; lat = 0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clock);
         if (|done === 1'b1) begin ok = 1'b1; lat = i; break; end
      end
   endtask

   task automatic wait_idle(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (busy === 1'b0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic set_frame(input logic [39:0] f);
      {hi, hf, ti, tf, cs} = f;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      total++; if ({gnt, done, busy, rd_valid, rd_error, dec_enable, dec_reset} !== '0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0", {gnt, done, busy, rd_valid, rd_error, dec_enable, dec_reset}); end
      total++; if ({rd_hi, rd_hf, rd_ti, rd_tf} !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rd_hi, rd_hf, rd_ti, rd_tf}); end
      reset = 1'b0;
      @(negedge clock);
      total++; if (dec_enable !== 1'b1) begin bad++; $display("FAIL dec_enable got=%b exp=1", dec_enable); end
   endtask

   task automatic test_round_robin;
      bit ok; int n, c1;
      set_frame(40'h30_01_18_02_4B);
      req = 2'b11;
      wait_start(10, ok, n); c1 = cyc;
      total++; if (!ok || gnt !== 2'b01) begin bad++; $display("FAIL rr_first ok=%b gnt=%b exp=01", ok, gnt); end
      wait_done(200, ok, n);
      total++; if (done !== 2'b01) begin bad++; $display("FAIL rr_done0 got=%b exp=01", done); end
      req = 2'b10;
      wait_start(400, ok, n);
      total++; if (!ok || gnt !== 2'b10) begin bad++; $display("FAIL rr_second ok=%b gnt=%b exp=10", ok, gnt); end
      total++; if (cyc - c1 < GAP) begin bad++; $display("FAIL rr_gap got=%0d exp>=%0d", cyc - c1, GAP); end
      wait_done(200, ok, n);
      total++; if (done !== 2'b10) begin bad++; $display("FAIL rr_done1 got=%b exp=10", done); end
      req = 2'b11;
      wait_start(400, ok, n);
      total++; if (!ok || gnt !== 2'b01) begin bad++; $display("FAIL rr_third ok=%b gnt=%b exp=01", ok, gnt); end
      wait_done(200, ok, n);
      total++; if (done !== 2'b01) begin bad++; $display("FAIL rr_done2 got=%b exp=01", done); end
      req = 2'b10;
      wait_done(600, ok, n);
      total++; if (done !== 2'b10) begin bad++; $display("FAIL rr_done3 got=%b exp=10", done); end
      total++; if (rd_hi !== 8'h30 || rd_tf !== 8'h02 || rd_valid !== 1'b1) begin bad++; $display("FAIL rr_latch hi=%h tf=%h valid=%b exp 30 02 1", rd_hi, rd_tf, rd_valid); end
      req = 2'b00;
      wait_idle(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_single;
      bit ok; int lat, n;
      set_frame(40'h37_00_19_00_50);
      req = 2'b01;
      wait_start(10, ok, lat);
      total++; if (!ok || lat !== 2) begin bad++; $display("FAIL start_latency ok=%b got=%0d exp=2", ok, lat); end
      total++; if (gnt !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL single_gnt gnt=%b busy=%b exp 01 1", gnt, busy); end
      wait_done(200, ok, n);
      total++; if (done !== 2'b01) begin bad++; $display("FAIL single_done got=%b exp=01", done); end
      total++; if (rd_hi !== 8'h37 || rd_ti !== 8'h19 || rd_hf !== 8'h00) begin bad++; $display("FAIL single_data hi=%h ti=%h hf=%h exp 37 19 00", rd_hi, rd_ti, rd_hf); end
      total++; if (rd_valid !== 1'b1 || rd_error !== 1'b0) begin bad++; $display("FAIL single_flags valid=%b err=%b exp 1 0", rd_valid, rd_error); end
      req = 2'b00;
      @(negedge clock);
      total++; if (done !== 2'b00) begin bad++; $display("FAIL done_width got=%b exp=00", done); end
      wait_idle(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_start_timeout;
      bit ok; int n, snap;
      set_frame(40'h11_22_33_44_AA);
      dead = 1'b1;
      snap = n_start;
      req = 2'b01;
      wait_start(10, ok, n);
      wait_done(3000, ok, n);
`ifdef SENSOR_RETRY_EN
      total++; if (n_start - snap !== TRIES) begin bad++; $display("FAIL timeout_tries got=%0d exp=%0d", n_start - snap, TRIES); end
`else
      total++; if (!ok || n !== STO + 2) begin bad++; $display("FAIL timeout_latency ok=%b got=%0d exp=%0d", ok, n, STO + 2); end
`endif
      total++; if (done !== 2'b01) begin bad++; $display("FAIL timeout_done got=%b exp=01", done); end
      total++; if (rd_error !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL timeout_flags err=%b valid=%b exp 1 0", rd_error, rd_valid); end
      total++; if (rd_hi !== 8'h37 || rd_ti !== 8'h19) begin bad++; $display("FAIL timeout_keep hi=%h ti=%h exp 37 19", rd_hi, rd_ti); end
      dead = 1'b0;
      req = 2'b00;
      wait_idle(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL timeout_idle busy=%b exp=0", busy); end
   endtask

   task automatic test_auto;
      bit ok; int n = 0, s0 = -1, s1 = -1, s2 = -1;
      bit saw_done = 1'b0, saw_gnt = 1'b0;
      set_frame(40'h2A_05_17_03_49);
      auto_en = 1'b1;
      for (int i = 0; i < 3500; i++) begin
         @(negedge clock);
         if (dec_reset === 1'b1) begin
            if (n == 0) s0 = cyc;
            if (n == 1) s1 = cyc;
            if (n == 2) s2 = cyc;
            n++;
         end
         if (done !== 2'b00) saw_done = 1'b1;
         if (gnt !== 2'b00) saw_gnt = 1'b1;
      end
      total++; if (n !== 3) begin bad++; $display("FAIL auto_count got=%0d exp=3", n); end
      total++; if (s1 - s0 !== PER || s2 - s1 !== PER) begin bad++; $display("FAIL auto_period got=%0d,%0d exp=%0d", s1 - s0, s2 - s1, PER); end
      total++; if (saw_done || saw_gnt) begin bad++; $display("FAIL auto_silent done=%b gnt=%b exp 0 0", saw_done, saw_gnt); end
      total++; if (rd_hi !== 8'h2A || rd_tf !== 8'h03 || rd_valid !== 1'b1 || rd_error !== 1'b0) begin bad++; $display("FAIL auto_latch hi=%h tf=%h valid=%b err=%b exp 2a 03 1 0", rd_hi, rd_tf, rd_valid, rd_error); end
      auto_en = 1'b0;
      wait_idle(400, ok);
      n = n_start;
      repeat (1100) @(negedge clock);
      total++; if (n_start - n !== 0) begin bad++; $display("FAIL auto_off got=%0d starts exp=0", n_start - n); end
   endtask

   task automatic test_bad_checksum;
      bit ok; int n, snap;
      set_frame(40'h40_01_20_02_64);
      snap = n_start;
      req = 2'b01;
      wait_done(2000, ok, n);
      total++; if (!ok || done !== 2'b01) begin bad++; $display("FAIL badcs_done ok=%b got=%b exp=01", ok, done); end
      total++; if (rd_error !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL badcs_flags err=%b valid=%b exp 1 0", rd_error, rd_valid); end
      total++; if (rd_hi !== 8'h2A) begin bad++; $display("FAIL badcs_keep hi=%h exp=2a", rd_hi); end
      total++; if (n_start - snap !== TRIES) begin bad++; $display("FAIL badcs_tries got=%0d exp=%0d", n_start - snap, TRIES); end
      req = 2'b00;
      wait_idle(400, ok);
   endtask

   task automatic test_reset_mid;
      bit ok; int n, snap;
      set_frame(40'h37_00_19_00_50);
      req = 2'b01;
      wait_start(10, ok, n);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (dec_hold === 1'b1) begin ok = 1'b1; break; end
      end
      total++; if (!ok) begin bad++; $display("FAIL mid_hold got=%b exp=1", dec_hold); end
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      #1;
      total++; if ({gnt, done, busy, rd_valid, rd_error, dec_enable, dec_reset, rd_hi, rd_ti} !== '0) begin bad++; $display("FAIL mid_reset got=%h exp=0", {gnt, done, busy, rd_valid, rd_error, dec_enable, dec_reset, rd_hi, rd_ti}); end
      @(negedge clock);
      reset = 1'b0;
      snap = n_start;
      wait_done(200, ok, n);
      total++; if (done !== 2'b01 || rd_hi !== 8'h37 || rd_valid !== 1'b1) begin bad++; $display("FAIL mid_recover done=%b hi=%h valid=%b exp 01 37 1", done, rd_hi, rd_valid); end
      total++; if (n_start - snap !== 1) begin bad++; $display("FAIL mid_starts got=%0d exp=1", n_start - snap); end
      req = 2'b00;
      wait_idle(400, ok);
   endtask

   task automatic test_zero_frame;
      bit ok; int n;
      set_frame(40'h0);
      req = 2'b01;
      wait_done(2000, ok, n);
      total++; if (!ok || done !== 2'b01) begin bad++; $display("FAIL zero_done ok=%b got=%b exp=01", ok, done); end
      total++; if (rd_error !== 1'b1 || rd_valid !== 1'b0 || rd_hi !== 8'h37) begin bad++; $display("FAIL zero_flags err=%b valid=%b hi=%h exp 1 0 37", rd_error, rd_valid, rd_hi); end
      req = 2'b00;
      wait_idle(400, ok);
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_single;
      test_start_timeout;
      test_auto;
      test_bad_checksum;
      test_reset_mid;
      test_zero_frame;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
